tick_counter_ctrl: RTL and testbench

Run-control sequencer for the divided-clock counter datapath. It consumes the single-cycle tick strobe produced by clk_divider (its ctrl_signal) and sequences a programmable up/down counter through idle, run, pause and done phases. It also accepts start/pause/clear/load commands from the user-I/O layer and reports count, status and a completion pulse to the display logic.

---
 rtl/tick_counter_ctrl.sv | 109 ++++++++++
 tb/tb_tick_counter_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_counter_ctrl.sv
// Run-control sequencer for a tick-driven up/down counter: idle/run/pause/done phases, user commands.
// Latency 1 clk from command or tick to count/state/done; no backpressure, every command is acted on or dropped in-cycle.
module tick_counter_ctrl #(
  parameter int WIDTH         = 8,
  parameter int DEFAULT_LIMIT = 9
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             tick,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_start_new;
  logic [WIDTH-1:0] w_start_cur;
  logic [WIDTH-1:0] w_term;

  // Start value for a fresh run uses the incoming dir; reload and terminal use the latched one.
  assign w_start_new = dir   ? '0 : r_limit;
  assign w_start_cur = r_dir ? '0 : r_limit;
  assign w_term      = r_dir ? r_limit : '0;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_limit <= WIDTH'(DEFAULT_LIMIT);
      r_dir   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clear) begin
        r_state <= ST_IDLE;
        r_count <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (pause) begin
              r_state <= r_state;
            end else if (start) begin
              r_dir   <= dir;
              r_count <= w_start_new;
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end else if (load) begin
              r_limit <= load_val;
            end
          end
          ST_RUN: begin
            if (pause) begin
              r_state <= ST_PAUSE;
            end else if (tick) begin
              if (r_count == w_term) begin
                r_done <= 1'b1;
                if (auto_reload) begin
                  r_count <= w_start_cur;
                end else begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                end
              end else if (r_dir) begin
                r_count <= r_count + 1'b1;
              end else begin
                r_count <= r_count - 1'b1;
              end
            end
          end
          ST_PAUSE: begin
            if (start) begin
              r_state <= ST_RUN;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign count = r_count;
  assign state = r_state;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_tick_counter_ctrl.sv
// Bench for tick_counter_ctrl: directed scenarios then random commands, scoreboarded against a phase model.
module tb_tick_counter_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_a = 1'b0;
  logic         tick = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0, load = 1'b0;
  logic         dir = 1'b1, auto_reload = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic [1:0]   state;
  logic         busy, done;

  tick_counter_ctrl #(.WIDTH(W), .DEFAULT_LIMIT(9)) dut (
    .clk(clk), .rst_a(rst_a), .tick(tick), .start(start), .pause(pause),
    .clear(clear), .load(load), .load_val(load_val), .dir(dir),
    .auto_reload(auto_reload), .count(count), .state(state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] c;
    logic [1:0]   s;
    logic         b;
    logic         d;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_want;
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model: phase 0=idle 1=run 2=pause 3=done
  int   m_st, m_cnt, m_lim, m_dir;
  bit   m_done;
  bit   cur_dir = 1'b1, cur_ar = 1'b0;
  int   cur_lv = 0;

  task automatic check(input string nm, input obs_t got, input obs_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: got count=%0d state=%0d busy=%0d done=%0d, want count=%0d state=%0d busy=%0d done=%0d",
                  nm, $time, got.c, got.s, got.b, got.d, want.c, want.s, want.b, want.d);
  endtask

  function automatic obs_t m_obs();
    obs_t o;
    o.c = m_cnt[W-1:0];
    o.s = m_st[1:0];
    o.b = (m_st == 1) || (m_st == 2);
    o.d = m_done;
    return o;
  endfunction

  task automatic m_reset();
    m_st = 0; m_cnt = 0; m_lim = 9; m_dir = 1; m_done = 0;
  endtask

  task automatic model(input bit s, p, c, l, t);
    int term;
    m_done = 0;
    if (c) begin
      m_st = 0;
      m_cnt = 0;
    end else begin
      case (m_st)
        0, 3: begin
          if (!p && s) begin
            m_dir = cur_dir;
            m_cnt = cur_dir ? 0 : m_lim;
            m_st  = 1;
          end else if (!p && l) begin
            m_lim = cur_lv;
          end
        end
        1: begin
          if (p) m_st = 2;
          else if (t) begin
            term = m_dir ? m_lim : 0;
            if (m_cnt == term) begin
              m_done = 1;
              if (cur_ar) m_cnt = m_dir ? 0 : m_lim;
              else m_st = 3;
            end else begin
              m_cnt = m_dir ? m_cnt + 1 : m_cnt - 1;
            end
          end
        end
        default: if (s) m_st = 1;
      endcase
    end
  endtask

  // One clock of stimulus; expectation for the following edge goes to the scoreboard.
  task automatic drive(input bit s, p, c, l, t);
    @(negedge clk);
    start = s; pause = p; clear = c; load = l; tick = t;
    dir = cur_dir; auto_reload = cur_ar; load_val = cur_lv[W-1:0];
    model(s, p, c, l, t);
    exp_q.push_back(m_obs());
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic tk(input int n, input int gap);
    repeat (n) begin
      drive(0, 0, 0, 0, 1);
      if (gap > 1) idle(gap - 1);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    start = 0; pause = 0; clear = 0; load = 0; tick = 0;
    rst_a = 1'b1;
    #1;
    m_reset();
    check("async_reset", {count, state, busy, done}, m_obs());
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        mon_want = exp_q.pop_front();
        check("cycle", {count, state, busy, done}, mon_want);
      end
    end
  end

  initial begin
    int r;
    #1 rst_a = 1'b1;
    #1;
    m_reset();
    check("reset_state", {count, state, busy, done}, m_obs());
    @(negedge clk);
    rst_a = 1'b0;

    // reset while running at count 5
    cur_dir = 1; cur_ar = 0;
    drive(1, 0, 0, 0, 0);
    tk(5, 1);
    async_reset();

    // up one-shot against default limit, extra ticks must not move count
    cur_dir = 1; cur_ar = 0;
    drive(1, 0, 0, 0, 0);
    tk(10, 4);
    tk(2, 2);

    // down with auto-reload, limit 3
    cur_lv = 3;
    drive(0, 0, 0, 1, 0);
    cur_dir = 0; cur_ar = 1;
    drive(1, 0, 0, 0, 0);
    tk(9, 2);

    // pause with coincident tick, ignored load, resume
    drive(0, 0, 1, 0, 0);
    cur_lv = 9;
    drive(0, 0, 0, 1, 0);
    cur_dir = 1; cur_ar = 0;
    drive(1, 0, 0, 0, 0);
    tk(4, 1);
    drive(0, 1, 0, 0, 1);
    tk(5, 2);
    cur_lv = 2;
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    tk(6, 1);

    // clear+start+tick together, then load while running
    drive(1, 0, 0, 0, 0);
    tk(2, 1);
    drive(1, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0);
    cur_lv = 2;
    drive(0, 0, 0, 1, 0);
    tk(11, 1);

    // zero limit: first tick terminates
    cur_lv = 0;
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    tk(1, 1);
    drive(1, 0, 0, 0, 0);
    tk(2, 1);

    // random commands, at most one per cycle; ticks only alone or with pause
    repeat (3000) begin
      cur_dir = 1'($urandom_range(0, 1));
      cur_ar  = 1'($urandom_range(0, 1));
      cur_lv  = $urandom_range(0, 12);
      r = $urandom_range(0, 99);
      if (r < 3)       drive(0, 0, 1, 0, 0);
      else if (r < 8)  drive(0, 1, 0, 0, 1'($urandom_range(0, 1)));
      else if (r < 16) drive(1, 0, 0, 0, 0);
      else if (r < 21) drive(0, 0, 0, 1, 0);
      else             drive(0, 0, 0, 0, 1'($urandom_range(0, 99) < 45));
    end
    idle(1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #5;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
